// File: rtl/alu_mc_if.sv
// alu_mc_if: operand/result handshake bundle for alu_mc.
// master = issuing controller plus result consumer, slave = the ALU.
interface alu_mc_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             zf;
    logic             cf;
    logic             vf;
    logic             dz;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, y, zf, cf, vf, dz
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, y, zf, cf, vf, dz
    );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle WIDTH-bit ALU with registered result/flags and valid/ready on both sides.
// Define ALU_MC_DIV_EN to build the iterative restoring divider for DIV/MOD (BUSY state).
module alu_mc #(
    parameter int WIDTH = 8
) (
    input  logic    clk,
    input  logic    rst,
    alu_mc_if.slave bus
);
    localparam int MSB = WIDTH - 1;
    localparam logic [WIDTH-1:0] WMOD = WIDTH'(WIDTH);

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_MUL   = 4'd2,
        OP_DIV   = 4'd3,
        OP_MOD   = 4'd4,
        OP_NOTA  = 4'd5,
        OP_LNOTB = 4'd6,
        OP_XOR   = 4'd7,
        OP_NOR   = 4'd8,
        OP_XNOR  = 4'd9,
        OP_SHL   = 4'd10,
        OP_AND   = 4'd11,
        OP_OR    = 4'd12,
        OP_INC   = 4'd13,
        OP_DEC   = 4'd14,
        OP_NAND  = 4'd15
    } op_t;

`ifdef ALU_MC_DIV_EN
    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;
`else
    typedef enum logic {IDLE, HOLD} state_t;
`endif

    state_t state, state_nx;

    logic             rdy;
    logic             load;
    logic [WIDTH-1:0] y_q;
    logic             zf_q, cf_q, vf_q, dz_q;

    logic [WIDTH:0]   ext;
    logic [WIDTH-1:0] shamt;
    logic [WIDTH-1:0] alu_r;
    logic             alu_c, alu_v, alu_d;

    // Single-cycle result computed straight from the bus; it is only sampled on an accept edge.
    always_comb begin
        ext   = '0;
        alu_r = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        alu_d = 1'b0;
        shamt = bus.b % WMOD;
        case (bus.op)
            OP_ADD: begin
                ext   = {1'b0, bus.a} + {1'b0, bus.b};
                alu_r = ext[MSB:0];
                alu_c = ext[WIDTH];
                alu_v = (bus.a[MSB] == bus.b[MSB]) && (alu_r[MSB] != bus.a[MSB]);
            end
            OP_SUB: begin
                ext   = {1'b0, bus.a} - {1'b0, bus.b};
                alu_r = ext[MSB:0];
                alu_c = ext[WIDTH];
                alu_v = (bus.a[MSB] != bus.b[MSB]) && (alu_r[MSB] != bus.a[MSB]);
            end
            OP_MUL:   alu_r = bus.a * bus.b;
`ifdef ALU_MC_DIV_EN
            OP_DIV: begin
                alu_r = '1;
                alu_d = (bus.b == '0);
            end
            OP_MOD: begin
                alu_r = bus.a;
                alu_d = (bus.b == '0);
            end
`else
            OP_DIV, OP_MOD: begin
                alu_r = '0;
                alu_d = 1'b1;
            end
`endif
            OP_NOTA:  alu_r = ~bus.a;
            OP_LNOTB: alu_r = {{(WIDTH-1){1'b0}}, (bus.b == '0)};
            OP_XOR:   alu_r = bus.a ^ bus.b;
            OP_NOR:   alu_r = ~(bus.a | bus.b);
            OP_XNOR:  alu_r = ~(bus.a ^ bus.b);
            OP_SHL:   alu_r = bus.a << shamt;
            OP_AND:   alu_r = bus.a & bus.b;
            OP_OR:    alu_r = bus.a | bus.b;
            OP_INC: begin
                ext   = {1'b0, bus.a} + (WIDTH+1)'(1);
                alu_r = ext[MSB:0];
                alu_c = ext[WIDTH];
                alu_v = ~bus.a[MSB] & alu_r[MSB];
            end
            OP_DEC: begin
                ext   = {1'b0, bus.a} - (WIDTH+1)'(1);
                alu_r = ext[MSB:0];
                alu_c = (bus.a == '0);
                alu_v = bus.a[MSB] & ~alu_r[MSB];
            end
            OP_NAND:  alu_r = ~(bus.a & bus.b);
            default:  alu_r = '0;
        endcase
    end

`ifdef ALU_MC_DIV_EN
    localparam int CW = $clog2(WIDTH + 1);

    logic             start_div;
    logic             div_done;
    logic             last;
    logic [WIDTH-1:0] rem, quo, dvs;
    logic             dmod;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   rem_sh, trial;
    logic [WIDTH-1:0] rem_nx, quo_nx;
    logic [WIDTH-1:0] div_r;

    assign last = (cnt == CW'(WIDTH - 1));

    // Restoring step: shift next dividend bit into the remainder, keep the trial subtraction if it did not borrow.
    always_comb begin
        rem_sh = {rem, quo[MSB]};
        trial  = rem_sh - {1'b0, dvs};
        if (!trial[WIDTH]) begin
            rem_nx = trial[MSB:0];
            quo_nx = {quo[MSB-1:0], 1'b1};
        end else begin
            rem_nx = rem_sh[MSB:0];
            quo_nx = {quo[MSB-1:0], 1'b0};
        end
        div_r = dmod ? rem_nx : quo_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem  <= '0;
            quo  <= '0;
            dvs  <= '0;
            dmod <= 1'b0;
            cnt  <= '0;
        end else if (start_div) begin
            rem  <= '0;
            quo  <= bus.a;
            dvs  <= bus.b;
            dmod <= (bus.op == OP_MOD);
            cnt  <= '0;
        end else if (state == BUSY) begin
            rem  <= rem_nx;
            quo  <= quo_nx;
            cnt  <= cnt + CW'(1);
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // HOLD with out_ready behaves exactly like IDLE for a new accept, giving back-to-back issue.
    always_comb begin
        state_nx  = state;
        rdy       = 1'b0;
        load      = 1'b0;
`ifdef ALU_MC_DIV_EN
        start_div = 1'b0;
        div_done  = 1'b0;
`endif
        case (state)
            IDLE, HOLD: begin
                rdy = (state == IDLE) || bus.out_ready;
                if (bus.in_valid && rdy) begin
`ifdef ALU_MC_DIV_EN
                    if ((bus.op == OP_DIV || bus.op == OP_MOD) && bus.b != '0) begin
                        start_div = 1'b1;
                        state_nx  = BUSY;
                    end else begin
                        load     = 1'b1;
                        state_nx = HOLD;
                    end
`else
                    load     = 1'b1;
                    state_nx = HOLD;
`endif
                end else if (state == HOLD && bus.out_ready) begin
                    state_nx = IDLE;
                end
            end
`ifdef ALU_MC_DIV_EN
            BUSY: begin
                if (last) begin
                    div_done = 1'b1;
                    state_nx = HOLD;
                end
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q  <= '0;
            zf_q <= 1'b0;
            cf_q <= 1'b0;
            vf_q <= 1'b0;
            dz_q <= 1'b0;
        end else if (load) begin
            y_q  <= alu_r;
            zf_q <= (alu_r == '0);
            cf_q <= alu_c;
            vf_q <= alu_v;
            dz_q <= alu_d;
        end
`ifdef ALU_MC_DIV_EN
        else if (div_done) begin
            y_q  <= div_r;
            zf_q <= (div_r == '0);
            cf_q <= 1'b0;
            vf_q <= 1'b0;
            dz_q <= 1'b0;
        end
`endif
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = (state == HOLD);
    assign bus.y         = y_q;
    assign bus.zf        = zf_q;
    assign bus.cf        = cf_q;
    assign bus.vf        = vf_q;
    assign bus.dz        = dz_q;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: scoreboard bench for alu_mc at WIDTH=8; divide expectations follow ALU_MC_DIV_EN.
module tb_alu_mc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   rnd_on = 1'b0;

    always #5 clk = ~clk;

    alu_mc_if #(.WIDTH(8)) bus ();

    alu_mc #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0]  op;
        logic [11:0] res;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    logic [3:0] bops [3];
    logic [7:0] bexp [3];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, want, $time);
    endtask

    // Reference result packed as {y, zf, cf, vf, dz}, computed with plain integer arithmetic.
    function automatic logic [11:0] model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] z);
        int ua = x;
        int ub = z;
        int sa = $signed(x);
        int sb = $signed(z);
        int r  = 0;
        logic c = 1'b0, v = 1'b0, d = 1'b0;
        logic [7:0] yy;
        case (o)
            4'd0: begin r = ua + ub; c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); end
            4'd1: begin r = ua - ub; c = (ua < ub); v = (sa - sb > 127) || (sa - sb < -128); end
            4'd2: r = ua * ub;
`ifdef ALU_MC_DIV_EN
            4'd3: begin if (ub == 0) begin r = 255; d = 1'b1; end else r = ua / ub; end
            4'd4: begin if (ub == 0) begin r = ua;  d = 1'b1; end else r = ua % ub; end
`else
            4'd3, 4'd4: begin r = 0; d = 1'b1; end
`endif
            4'd5:  r = 255 - ua;
            4'd6:  r = (ub == 0) ? 1 : 0;
            4'd7:  r = ua ^ ub;
            4'd8:  r = 255 - (ua | ub);
            4'd9:  r = 255 - (ua ^ ub);
            4'd10: r = ua << (ub % 8);
            4'd11: r = ua & ub;
            4'd12: r = ua | ub;
            4'd13: begin r = ua + 1; c = (ua == 255); v = (sa == 127); end
            4'd14: begin r = ua - 1; c = (ua == 0);   v = (sa == -128); end
            default: r = 255 - (ua & ub);
        endcase
        yy = r[7:0];
        return {yy, (yy == 8'd0), c, v, d};
    endfunction

    // Push at accept, pop at output handshake; both observed at the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("sb_unexpected_out", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk($sformatf("op%0d_res", e.op), {bus.y, bus.zf, bus.cf, bus.vf, bus.dz}, e.res);
                end
            end
            if (bus.in_valid && bus.in_ready)
                q.push_back('{op: bus.op, res: model(bus.op, bus.a, bus.b)});
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (rnd_on) bus.out_ready = 1'($urandom_range(0, 1));
    end

    task automatic issue(input logic [3:0] o, input logic [7:0] x, input logic [7:0] z);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.op = o;
        bus.a  = x;
        bus.b  = z;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) chk("issue_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.op = 4'($urandom);
        bus.a  = 8'($urandom);
        bus.b  = 8'($urandom);
    endtask

    task automatic div_latency(input logic [3:0] o, input logic [7:0] x, input logic [7:0] z);
        int cyc = 0;
        bit rdy_seen = 1'b0;
        issue(o, x, z);
        @(negedge clk);
        while (!bus.out_valid && cyc < 40) begin
            if (bus.in_ready) rdy_seen = 1'b1;
            cyc++;
            @(negedge clk);
        end
`ifdef ALU_MC_DIV_EN
        chk($sformatf("div_lat_op%0d", o), cyc, 8);
`else
        chk($sformatf("div_lat_op%0d", o), cyc, 0);
`endif
        chk($sformatf("div_busy_rdy_op%0d", o), rdy_seen, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.op        = '0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        bops = '{4'd11, 4'd12, 4'd10};
        bexp = '{8'h01, 8'h89, 8'h02};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_y", bus.y, 0);
        chk("rst_flags", {bus.zf, bus.cf, bus.vf, bus.dz}, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;

        bus.out_ready = 1'b1;
        issue(4'd0, 8'd200, 8'd100);
        issue(4'd1, 8'd5, 8'd10);
        issue(4'd0, 8'd100, 8'd100);
        issue(4'd14, 8'd0, 8'd0);
        issue(4'd13, 8'd127, 8'd0);
        issue(4'd14, 8'h80, 8'd0);
        issue(4'd3, 8'd9, 8'd0);
        issue(4'd4, 8'd9, 8'd0);
        issue(4'd6, 8'd0, 8'd0);
        issue(4'd2, 8'd13, 8'd21);
        div_latency(4'd3, 8'd200, 8'd7);
        div_latency(4'd4, 8'd200, 8'd7);

        // Backpressure: result must hold while a pending in_valid is refused.
        repeat (2) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        issue(4'd7, 8'hF0, 8'h3C);
        bus.in_valid = 1'b1;
        bus.op = 4'd0;
        bus.a  = 8'd1;
        bus.b  = 8'd2;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_y", bus.y, 8'hCC);
            chk("bp_in_ready", bus.in_ready, 0);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", bus.in_ready, 1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        chk("bp_new_valid", bus.out_valid, 1);
        chk("bp_new_y", bus.y, 8'd3);
        @(posedge clk);
        #1;

        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.op = bops[i];
            bus.a  = 8'h81;
            bus.b  = 8'd9;
            @(negedge clk);
            chk("b2b_in_ready", bus.in_ready, 1);
            if (i > 0) begin
                chk("b2b_out_valid", bus.out_valid, 1);
                chk("b2b_y", bus.y, bexp[i-1]);
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_last_valid", bus.out_valid, 1);
        chk("b2b_last_y", bus.y, bexp[2]);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("b2b_drained", bus.out_valid, 0);
        @(posedge clk);
        #1;
        issue(4'd6, 8'd55, 8'd0);

        // Reset while the divide is in flight (or held, without the divider) drops the result.
        repeat (2) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        issue(4'd3, 8'd200, 8'd7);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        q.delete();
        @(negedge clk);
        chk("mrst_out_valid", bus.out_valid, 0);
        chk("mrst_y", bus.y, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        begin
            bit stale = 1'b0;
            @(negedge clk);
            chk("mrst_in_ready", bus.in_ready, 1);
            for (int i = 0; i < 12; i++) begin
                if (bus.out_valid) stale = 1'b1;
                @(negedge clk);
            end
            chk("mrst_no_stale", stale, 0);
        end
        @(posedge clk);
        #1;

        rnd_on = 1'b1;
        repeat (60) begin
            logic [3:0] o;
            logic [7:0] x, z;
            o = 4'($urandom_range(0, 15));
            x = 8'($urandom);
            z = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            issue(o, x, z);
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rnd_on = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU; successor to the team's 4-bit combinational ALU. Keeps the same 16-opcode map, generalised to WIDTH bits. Adds registered outputs, status flags, a valid/ready handshake on both sides, and an iterative divider for DIV/MOD. It sits between an operand-issuing controller and a result consumer that may stall.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands/opcode valid
- in_ready  out  1  block accepts operands this cycle
- op  in  4  opcode
- a, b  in  WIDTH  unsigned operands
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer accepts result this cycle
- y  out  WIDTH  result
- zf, cf, vf, dz  out  1 each  zero, carry/borrow, signed overflow, divide-by-zero

## Operation
- Opcode map, all results truncated to WIDTH:
  - 0 a+b, 1 a−b, 2 a*b (low WIDTH bits), 3 a/b, 4 a%b
  - 5 ~a, 6 logical !b (1 if b==0, else 0), 7 a^b, 8 ~(a|b), 9 ~(a^b)
  - 10 a<<(b mod WIDTH), 11 a&b, 12 a|b, 13 a+1, 14 a−1, 15 ~(a&b) (bitwise)
- Flags:
  - zf = (y==0) for every op.
  - cf = carry-out for ops 0 and 13; borrow (a<b, or a==0 for op 14) for ops 1 and 14; 0 otherwise.
  - vf = signed two's-complement overflow for ops 0, 1, 13, 14; 0 otherwise.
  - dz = 1 only for ops 3 and 4 with b==0.
- Divide by zero: y = all-ones for op 3; y = a for op 4. Completes like a single-cycle op.
- FSM states: IDLE, BUSY, HOLD.
  - IDLE: in_ready=1. On accept, a divide with b≠0 goes to BUSY; anything else loads y/flags and goes to HOLD.
  - BUSY: restoring divider, one quotient bit per cycle, WIDTH cycles. After the last iteration, loads y/flags and goes to HOLD. in_ready=0.
  - HOLD: out_valid=1. y/flags are stable until out_ready=1.
    - out_ready=1 with no new accept: go to IDLE.
    - out_ready=1 with a simultaneous accept: behave as IDLE accept, which gives back-to-back throughput.
- in_ready = (state==IDLE) | (state==HOLD & out_ready). Accept = in_valid & in_ready.
- Opcodes and operands are captured at accept. Input changes after accept have no effect.

## Timing
- Reset (async assert, sync release): state=IDLE, y=0, zf=cf=vf=dz=0, out_valid=0, in_ready=1 from the first cycle after release. Reset mid-BUSY abandons the divide with no output.
- Single-cycle ops: accept at edge k gives out_valid=1 from edge k, visible in cycle k+1.
- Divide (b≠0): accept at edge k; BUSY for edges k+1..k+WIDTH; out_valid=1 after edge k+WIDTH (latency WIDTH+1 cycles).
- Sustained throughput: 1 op/cycle for non-divide ops when out_ready stays high. A divide blocks input for WIDTH cycles.
- out_valid drops the edge after out_ready=1 unless a new result loads on the same edge.
- in_valid held with in_ready=0: no capture. No combinational path from out_ready to y.

## Configuration
- ALU_MC_DIV_EN defined: ops 3/4 use the iterative divider as above. BUSY state is present.
- ALU_MC_DIV_EN undefined: divider and BUSY state are removed. Ops 3/4 complete single-cycle with y=0, zf=1, and dz=1 regardless of b, flagging unsupported. All other ops are unchanged.

## Test plan (WIDTH=8)
- Reset mid-stream: assert rst during BUSY of 200/7 -> out_valid=0, y=0, in_ready=1 after release, no stale result.
- Add/sub flags: op0 a=200 b=100 -> y=44 cf=1 vf=0. Op1 a=5 b=10 -> y=251 cf=1. Op0 a=100 b=100 -> y=200 vf=1. Op14 a=0 -> y=255 cf=1.
- Divide (macro on): op3 a=200 b=7 -> y=28 exactly 9 cycles after accept, in_ready=0 for 8 cycles. Op4 same operands -> y=4.
- Divide by zero: op3 a=9 b=0 -> y=255 dz=1 in 1 cycle. Op4 a=9 b=0 -> y=9 dz=1.
- Backpressure: hold out_ready=0 for 5 cycles after op7 a=0xF0 b=0x3C -> y=0xCC stable and in_ready=0 throughout. Raise out_ready with in_valid=1 -> new op accepted the same edge.
- Back-to-back: ops 11, 12, 10 (a=0x81 b=9) streamed with out_ready=1 -> results 0x01, 0x89, 0x02 on consecutive cycles. Op6 b=0 -> y=1.
